// File: rtl/ctrl_sequencer_if.sv
// Bundle between the control sequencer, instruction memory and ALU.
// The sequencer takes the master view; memory/ALU/testbench take the slave view.
interface ctrl_sequencer_if #(
    parameter int PC_WIDTH = 16
);
    logic                O_mem_req;
    logic [PC_WIDTH-1:0] O_mem_addr;
    logic                I_mem_ack;
    logic [15:0]         I_mem_data;
    logic [15:0]         I_aluResult;
    logic                I_shldBranch;
    logic [4:0]          O_aluop;
    logic [2:0]          O_selD;
    logic [2:0]          O_selA;
    logic [2:0]          O_selB;
    logic [7:0]          O_imm;
    logic                O_en_fetch;
    logic                O_en_decode;
    logic                O_en_regread;
    logic                O_en_alu;
    logic                O_en_wb;
    logic                O_regwe;
    logic [PC_WIDTH-1:0] O_pc;

    modport master (
        output O_mem_req, O_mem_addr, O_aluop, O_selD, O_selA, O_selB, O_imm,
               O_en_fetch, O_en_decode, O_en_regread, O_en_alu, O_en_wb,
               O_regwe, O_pc,
        input  I_mem_ack, I_mem_data, I_aluResult, I_shldBranch
    );

    modport slave (
        input  O_mem_req, O_mem_addr, O_aluop, O_selD, O_selA, O_selB, O_imm,
               O_en_fetch, O_en_decode, O_en_regread, O_en_alu, O_en_wb,
               O_regwe, O_pc,
        output I_mem_ack, I_mem_data, I_aluResult, I_shldBranch
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/REGREAD/EXEC/WB sequencer and instruction decoder
// feeding the 16-bit ALU; the PC is updated from the ALU branch result in WB.
module ctrl_sequencer #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic             I_clk,
    input  logic             I_rst,
    ctrl_sequencer_if.master bus
);
    // One-hot encoding so each state bit is directly a registered stage enable.
    typedef enum logic [4:0] {
        S_FETCH   = 5'b00001,
        S_DECODE  = 5'b00010,
        S_REGREAD = 5'b00100,
        S_EXEC    = 5'b01000,
        S_WB      = 5'b10000
    } state_t;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic                en_alu_q, en_alu_d;
    logic                regwe_q, regwe_d;
    logic [3:0]          opcode;

    assign opcode = ir_q[15:12];

    function automatic logic op_defined(input logic [3:0] op);
        return !(op inside {4'd6, 4'd7, 4'd14, 4'd15});
    endfunction

    function automatic logic op_writes_reg(input logic [3:0] op);
        return (op <= 4'd5) || (op inside {[4'd8:4'd11]});
    endfunction

    function automatic logic op_is_jump(input logic [3:0] op);
        return op inside {4'd12, 4'd13};
    endfunction

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        en_alu_d = 1'b0;
        regwe_d  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                // After reset req starts low for one cycle; an ack then is ignored.
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (bus.I_mem_ack) begin
                    ir_d    = bus.I_mem_data;
                    req_d   = 1'b0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_REGREAD;
            S_REGREAD: begin
                state_d  = S_EXEC;
                en_alu_d = op_defined(opcode);
            end
            S_EXEC: begin
                state_d = S_WB;
                regwe_d = op_writes_reg(opcode);
            end
            S_WB: begin
                state_d = S_FETCH;
                req_d   = 1'b1;
                if (bus.I_shldBranch && op_is_jump(opcode))
                    pc_d = bus.I_aluResult[PC_WIDTH-1:0];
                else
                    pc_d = pc_q + PC_WIDTH'(1);
            end
            default: begin
                state_d = S_FETCH;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q  <= S_FETCH;
            req_q    <= 1'b0;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            en_alu_q <= 1'b0;
            regwe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            en_alu_q <= en_alu_d;
            regwe_q  <= regwe_d;
        end
    end

    assign bus.O_mem_req    = req_q;
    assign bus.O_mem_addr   = pc_q;
    assign bus.O_pc         = pc_q;
    assign bus.O_aluop      = {ir_q[15:12], ir_q[8]};
    assign bus.O_selD       = ir_q[11:9];
    assign bus.O_selA       = ir_q[7:5];
    assign bus.O_selB       = ir_q[4:2];
    assign bus.O_imm        = ir_q[7:0];
    assign bus.O_en_fetch   = state_q[0];
    assign bus.O_en_decode  = state_q[1];
    assign bus.O_en_regread = state_q[2];
    assign bus.O_en_alu     = en_alu_q;
    assign bus.O_en_wb      = state_q[4];
    assign bus.O_regwe      = regwe_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomised bench for ctrl_sequencer: an instruction-level model predicts every
// cycle's outputs from the stage timing rules and a compare process checks them.
module tb_ctrl_sequencer;
    localparam logic [4:0] E_F = 5'b10000;
    localparam logic [4:0] E_D = 5'b01000;
    localparam logic [4:0] E_R = 5'b00100;
    localparam logic [4:0] E_A = 5'b00010;
    localparam logic [4:0] E_W = 5'b00001;
    localparam logic [4:0] E_N = 5'b00000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_sequencer_if #(.PC_WIDTH(16)) bus ();

    ctrl_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_ir = 16'h0000;
    bit          after_rst = 1'b1;

    logic        chk_en = 1'b0;
    logic [4:0]  exp_en;
    logic        exp_req;
    logic        exp_we;
    logic [15:0] exp_pc;
    logic [15:0] exp_ir;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_writes(input logic [3:0] op);
        return (op <= 4'd5) || (op >= 4'd8 && op <= 4'd11);
    endfunction

    function automatic bit m_defined(input logic [3:0] op);
        return !(op == 4'd6 || op == 4'd7 || op == 4'd14 || op == 4'd15);
    endfunction

    function automatic bit m_jump(input logic [3:0] op);
        return op == 4'd12 || op == 4'd13;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [4:0] en;
            en = {bus.O_en_fetch, bus.O_en_decode, bus.O_en_regread, bus.O_en_alu, bus.O_en_wb};
            check("enables", 32'(en), 32'(exp_en));
            check("onehot", 32'($countones(en)), (exp_en == 5'd0) ? 32'd0 : 32'd1);
            check("mem_req", 32'(bus.O_mem_req), 32'(exp_req));
            check("mem_addr", 32'(bus.O_mem_addr), 32'(exp_pc));
            check("pc", 32'(bus.O_pc), 32'(exp_pc));
            check("regwe", 32'(bus.O_regwe), 32'(exp_we));
            check("decode",
                  32'({bus.O_aluop, bus.O_selD, bus.O_selA, bus.O_selB, bus.O_imm}),
                  32'({exp_ir[15:12], exp_ir[8], exp_ir[11:9], exp_ir[7:5], exp_ir[4:2], exp_ir[7:0]}));
        end
    end

    // Publish this cycle's expectations, then advance to just after the next edge.
    task automatic step(input logic [4:0] en, input logic req, input logic we);
        exp_en  = en;
        exp_req = req;
        exp_we  = we;
        exp_pc  = m_pc;
        exp_ir  = m_ir;
        chk_en  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One instruction: optional post-reset idle cycle, w wait cycles, then
    // DECODE/REGREAD/EXEC/WB. rst_at = cycle index at which I_rst is held high.
    task automatic do_instr(input logic [15:0] instr, input int w, input logic br,
                            input logic [15:0] res, input int rst_at, input logic junk_ack);
        int         lead;
        int         total;
        logic [3:0] op;
        lead      = after_rst ? 1 : 0;
        total     = lead + w + 5;
        op        = instr[15:12];
        after_rst = 1'b0;
        for (int k = 0; k < total; k++) begin
            int ph;
            bus.I_mem_ack    = 1'($urandom);
            bus.I_mem_data   = 16'($urandom);
            bus.I_shldBranch = 1'($urandom);
            bus.I_aluResult  = 16'($urandom);
            rst = (k == rst_at);
            ph  = k - lead - w;
            if (k < lead) begin
                bus.I_mem_ack = junk_ack;
                step(E_F, 1'b0, 1'b0);
            end else if (ph <= 0) begin
                bus.I_mem_ack = (ph == 0);
                if (ph == 0) bus.I_mem_data = instr;
                step(E_F, 1'b1, 1'b0);
            end else if (ph == 1) begin
                m_ir = instr;
                step(E_D, 1'b0, 1'b0);
            end else if (ph == 2) begin
                step(E_R, 1'b0, 1'b0);
            end else if (ph == 3) begin
                step(m_defined(op) ? E_A : E_N, 1'b0, 1'b0);
            end else begin
                bus.I_shldBranch = br;
                bus.I_aluResult  = res;
                step(E_W, 1'b0, m_writes(op));
                if (k != rst_at) m_pc = (br && m_jump(op)) ? res : m_pc + 16'd1;
            end
            if (k == rst_at) begin
                rst       = 1'b0;
                m_pc      = 16'h0000;
                m_ir      = 16'h0000;
                after_rst = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bus.I_mem_ack    = 1'b0;
        bus.I_mem_data   = 16'h0000;
        bus.I_aluResult  = 16'h0000;
        bus.I_shldBranch = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(E_F, 1'b0, 1'b0);

        // Add r5 = r1 + r5, ack after three wait cycles
        do_instr(16'h0A34, 3, 1'b1, 16'h1234, -1, 1'b1);
        check("add_pc", 32'(bus.O_pc), 32'h0001);
        check("add_aluop", 32'(bus.O_aluop), 32'h00);
        check("add_selD", 32'(bus.O_selD), 32'd5);
        check("add_selA", 32'(bus.O_selA), 32'd1);
        check("add_selB", 32'(bus.O_selB), 32'd5);

        // JMPR taken, then not taken
        do_instr(16'hD000, 0, 1'b1, 16'h0040, -1, 1'b0);
        check("jmp_taken_pc", 32'(bus.O_pc), 32'h0040);
        check("jmp_taken_addr", 32'(bus.O_mem_addr), 32'h0040);
        check("jmp_aluop", 32'(bus.O_aluop), 32'h1A);
        do_instr(16'hD000, 1, 1'b0, 16'h0080, -1, 1'b0);
        check("jmp_nottaken_pc", 32'(bus.O_pc), 32'h0041);

        // Undefined opcode behaves as NOP
        do_instr(16'hE123, 2, 1'b1, 16'h0100, -1, 1'b0);
        check("nop_pc", 32'(bus.O_pc), 32'h0042);

        // Reset during EXEC with PC = 7
        do_instr(16'hC000, 0, 1'b1, 16'h0007, -1, 1'b0);
        check("pc_at_7", 32'(bus.O_pc), 32'h0007);
        do_instr(16'h1234, 1, 1'b0, 16'h0000, 4, 1'b0);
        check("rst_pc", 32'(bus.O_pc), 32'h0000);
        check("rst_req_low", 32'(bus.O_mem_req), 32'h0);
        do_instr(16'h3000, 0, 1'b0, 16'h0000, -1, 1'b1);
        check("post_rst_pc", 32'(bus.O_pc), 32'h0001);

        // PC wrap from all-ones
        do_instr(16'hD000, 0, 1'b1, 16'hFFFF, -1, 1'b0);
        check("pc_ffff", 32'(bus.O_pc), 32'hFFFF);
        do_instr(16'h2000, 1, 1'b1, 16'h5555, -1, 1'b0);
        check("pc_wrap", 32'(bus.O_pc), 32'h0000);

        // Randomised instruction stream with occasional resets
        for (int i = 0; i < 300; i++) begin
            int          w;
            int          rat;
            logic [15:0] ins;
            ins = 16'($urandom);
            w   = int'($urandom_range(0, 3));
            rat = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 8)) : -1;
            do_instr(ins, w, 1'($urandom), 16'($urandom), rat, 1'($urandom));
        end

        chk_en = 1'b0;
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
